dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the data-memory access interface driven by the memory stage of the pipeline core. It accepts one load/store request at a time over a valid/ready handshake and performs the access after a programmable number of wait states. It returns a response over a second valid/ready handshake. It replaces the zero-latency data memory so that the pipeline's stall logic can be exercised against realistic memory latency.

## Interface

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array.
- WAIT_CYCLES, 2: wait states between request acceptance and the memory access; 0 is legal.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables; bit i selects byte lane i (bits 8i+7:8i); ignored on loads.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  access rejected (misaligned or out of range).

## Operation

- States are IDLE, WAIT and RESP. req_ready = (state == IDLE).
- Accept: in IDLE with req_valid=1, the request is captured at the edge, including write, addr, wdata and be.
  - If WAIT_CYCLES=0, the access is performed at that same edge and the FSM goes to RESP.
  - Otherwise cnt <= WAIT_CYCLES-1 and the FSM goes to WAIT.
- WAIT: if cnt==0, the access is performed at the edge and the FSM goes to RESP; otherwise cnt decrements.
- Access: word index = addr[31:2].
  - Error if addr[1:0]!=0 or index >= DEPTH_WORDS. On error the array is untouched, rsp_err=1 and rsp_rdata=0.
  - Store: each lane with be[i]=1 is written. be=4'b0000 is a legal no-op with rsp_err=0. rsp_rdata=0.
  - Load: the full word is registered into rsp_rdata.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready, then the FSM goes to IDLE.
- Requests presented outside IDLE are ignored; the initiator must hold them.
- Array contents are not cleared by reset and power up as X.
- Width rules: cnt is $clog2(WAIT_CYCLES+1) bits, minimum 1. Index compare uses the full 30-bit addr[31:2].

## Timing

- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, cnt 0.
- Latency: if the request is accepted at edge E, rsp_valid is first high in the cycle after edge E+WAIT_CYCLES.
  - WAIT_CYCLES=0 gives 1 cycle; the default gives 3 cycles.
- Throughput: at most one request per WAIT_CYCLES+2 cycles. req_ready returns in the cycle after the response handshake, so there is no same-cycle re-accept.
- rsp_ready may be high before rsp_valid; the handshake completes in the first RESP cycle.
- Reset mid-operation: rst=1 at any edge forces the reset values.
  - A store still in WAIT is dropped and the array is unchanged.
  - A store already performed stays written.
- rst has priority over all handshakes at the same edge.

## Structure

- Package dmem_pkg holds:
  - the state enum (DMEM_IDLE, DMEM_WAIT, DMEM_RESP);
  - the word and byte-enable widths (32, 4);
  - a function for the alignment/range check.
- Sub-module dmem_array holds DEPTH_WORDS x 32 storage with one port: a byte-enabled synchronous write and a registered read, both gated by a single access strobe from the FSM.
- dmem_responder holds the FSM, counter, request capture and response registers.

## Test plan

- Reset then idle: after rst is released, req_ready=1, rsp_valid=0 and rsp_rdata=0, stable for 10 cycles with no requests.
- Store then load, WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10.
  - The load returns 0xDEADBEEF with rsp_err=0.
  - rsp_valid rises 3 cycles after each accept edge.
- Byte lanes: store 0x11223344 at 0x20, then store 0xAABBCCDD with be 4'b0101; the load returns 0x11BB33DD.
- Errors:
  - Load at 0x22 gives rsp_err=1 and rsp_rdata=0.
  - Store at DEPTH_WORDS*4 gives rsp_err=1, and a subsequent load of index 0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0.
  - After the handshake, req_ready=1 on the next cycle.
- Reset mid-store: store 0x55 to 0x40, assert rst while in WAIT.
  - The FSM returns to IDLE with all reset values.
  - A load of 0x40 returns the previous contents.
- Also run with WAIT_CYCLES=0 and check 1-cycle latency.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, widths and the address legality check for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // Legal access: word aligned and the full 30-bit word index inside the array.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: byte-enabled synchronous write, registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              access,
  input  logic              write,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  // Contents are deliberately not reset; they power up unknown.
  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // One access per strobe: stores update enabled lanes, loads register the word.
  always_ff @(posedge clk) begin
    if (access) begin
      if (write) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// response held until the initiator takes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic              cap_write;
  logic [31:0]       cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [BE_W-1:0]   cap_be;
  logic              rsp_load;   // response carries array read data

  logic              acc_fire;
  logic              acc_write;
  logic              acc_ok;
  logic [31:0]       acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic [WORD_W-1:0] arr_rdata;

  assign req_ready = (state == DMEM_IDLE);
  assign rsp_valid = (state == DMEM_RESP);
  // Array read register is only meaningful for a legal load; everything else returns 0.
  assign rsp_rdata = rsp_load ? arr_rdata : '0;

  // Access happens at the accept edge with no wait states (straight from the
  // request bus), otherwise at the last WAIT edge from the captured request.
  always_comb begin
    acc_fire  = 1'b0;
    acc_write = cap_write;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_be    = cap_be;
    if (WAIT_CYCLES == 0) begin
      acc_fire  = (state == DMEM_IDLE) && req_valid;
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_fire  = (state == DMEM_WAIT) && (cnt == '0);
    end
    acc_ok = addr_ok(acc_addr, DEPTH_WORDS);
  end

  // FSM, wait counter, request capture and response status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DMEM_IDLE;
      cnt      <= '0;
      rsp_err  <= 1'b0;
      rsp_load <= 1'b0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
            if (WAIT_CYCLES == 0) begin
              state <= DMEM_RESP;
            end else begin
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
              state <= DMEM_WAIT;
            end
          end
        end
        DMEM_WAIT: begin
          if (cnt == '0) state <= DMEM_RESP;
          else           cnt   <= cnt - CNT_W'(1);
        end
        DMEM_RESP: begin
          if (rsp_ready) state <= DMEM_IDLE;
        end
        default: state <= DMEM_IDLE;
      endcase
      if (acc_fire) begin
        rsp_err  <= !acc_ok;
        rsp_load <= acc_ok && !acc_write;
      end
    end
  end

  // Reset gates the strobe so a store coinciding with reset never lands.
  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk    (clk),
    .access (acc_fire && acc_ok && !rst),
    .write  (acc_write),
    .idx    (acc_addr[IDX_W+1:2]),
    .wdata  (acc_wdata),
    .be     (acc_be),
    .rdata  (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed vector table on two configurations (2 and 0
// wait states), reset-in-WAIT sequence, and randomized traffic vs a word model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int total = 0;
  int bad   = 0;
  int wc [2] = '{2, 0};

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dly;     // cycles of rsp_ready=0 in RESP; -1 = ready before valid
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  // Word model for the random region (words 128..143).
  logic [31:0] mdl [2][16];

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", name, d, act, exp, $time);
    end
  endtask

  // One full request/response transaction with latency and hold checks.
  task automatic do_txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int dly,
                        output logic [31:0] rd, output logic er);
    int n;
    bit got;
    @(negedge clk);
    chk("req_ready_idle", d, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd; req_be[d] = be;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = $urandom; req_be[d] = 4'($urandom);
    if (dly < 0) rsp_ready[d] = 1'b1;
    n = 0; got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid[d]) begin got = 1; break; end
      n++;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL rsp_timeout dut%0d actual=no_rsp_valid expected=rsp_valid", d);
      rsp_ready[d] = 1'b0;
      rd = '0; er = 1'b0;
      return;
    end
    chk("latency_edges_after_accept", d, 32'(n), 32'(wc[d]));
    rd = rsp_rdata[d]; er = rsp_err[d];
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("hold_valid", d, 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", d, rsp_rdata[d], rd);
      chk("hold_err",   d, 32'(rsp_err[d]), 32'(er));
      chk("hold_req_ready", d, 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk("req_ready_after_hs", d, 32'(req_ready[d]), 32'd1);
    chk("valid_low_after_hs", d, 32'(rsp_valid[d]), 32'd0);
  endtask

  task automatic chk_reset_vals(input int d);
    chk("rst_req_ready", d, 32'(req_ready[d]), 32'd1);
    chk("rst_rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
    chk("rst_rsp_rdata", d, rsp_rdata[d], 32'd0);
    chk("rst_rsp_err",   d, 32'(rsp_err[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a, wd, exp_rd;
    logic [3:0]  be;
    logic        w, exp_er;
    int          kind, idx;

    vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF,    0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,       32'h0,        4'h0,    0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF,    0, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'b0101, 0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,       32'h0,        4'hF,    1, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h22,       32'h0,        4'hF,    0, 32'h0,        1'b1};
    vecs[6]  = '{1'b1, 32'h0,        32'hCAFEF00D, 4'hF,    0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h1000,     32'h12345678, 4'hF,    0, 32'h0,        1'b1};
    vecs[8]  = '{1'b1, 32'hFFFFFFFC, 32'h12345678, 4'hF,    0, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 32'h0,        32'h0,        4'h0,    5, 32'hCAFEF00D, 1'b0};
    vecs[10] = '{1'b1, 32'h40,       32'h77777777, 4'hF,   -1, 32'h0,        1'b0};
    vecs[11] = '{1'b1, 32'h40,       32'h00000055, 4'h0,    0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'h40,       32'h0,        4'h0,    2, 32'h77777777, 1'b0};
    vecs[13] = '{1'b1, 32'hFFC,      32'h0A0B0C0D, 4'hF,    0, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'hFFC,      32'h0,        4'h0,   -1, 32'h0A0B0C0D, 1'b0};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_write[d] = 0; req_addr[d] = 0; req_wdata[d] = 0; req_be[d] = 0; rsp_ready[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset: outputs at reset values for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk_reset_vals(d);
    end

    // Directed table on both configurations.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 15; i++) begin
        do_txn(d, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].dly, rd, er);
        chk($sformatf("vec%0d_rdata", i), d, rd, vecs[i].exp_rdata);
        chk($sformatf("vec%0d_err", i), d, 32'(er), 32'(vecs[i].exp_err));
      end
    end

    // Reset while a store sits in WAIT: dropped, outputs return to reset values.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h40; req_wdata[0] = 32'h55; req_be[0] = 4'hF;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("in_wait_req_ready", 0, 32'(req_ready[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_reset_vals(0);
    end
    do_txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd, er);
    chk("after_rst_load_rdata", 0, rd, 32'h77777777);
    chk("after_rst_load_err", 0, 32'(er), 32'd0);

    // Randomized traffic against the word model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        mdl[d][i] = $urandom;
        do_txn(d, 1'b1, 32'h200 + 32'(i * 4), mdl[d][i], 4'hF, 0, rd, er);
        chk("init_err", d, 32'(er), 32'd0);
      end
      for (int t = 0; t < 40; t++) begin
        kind = $urandom_range(0, 7);
        idx  = $urandom_range(0, 15);
        a    = 32'h200 + 32'(idx * 4);
        if (kind == 6) a = a + 32'($urandom_range(1, 3));
        if (kind == 7) a = ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 255) * 4)
                                                       : 32'hFFFF0000 | 32'($urandom_range(0, 255) * 4);
        w  = 1'($urandom);
        wd = $urandom;
        be = 4'($urandom);
        exp_er = (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH));
        exp_rd = 32'h0;
        if (!exp_er) begin
          if (w) begin
            for (int b = 0; b < 4; b++) if (be[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
          end else begin
            exp_rd = mdl[d][idx];
          end
        end
        do_txn(d, w, a, wd, be, $urandom_range(0, 4) - 1, rd, er);
        chk("rand_rdata", d, rd, exp_rd);
        chk("rand_err", d, 32'(er), 32'(exp_er));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
